// File: rtl/gate_sweep_checker.sv
// Sweeps all 2^N input vectors through a downstream NOR gate and checks its returned output.
// Optional macro SWEEP_TRUTH_TABLE_EN adds the tt port holding the sampled truth table.
module gate_sweep_checker #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [N-1:0]   vec,
    input  logic           y_in,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [N:0]     err_cnt,
    output logic [N-1:0]   first_err
`ifdef SWEEP_TRUTH_TABLE_EN
    ,
    output logic [(2**N)-1:0] tt
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [N:0] ERR_MAX = (N+1)'(2**N);

    state_t         state_q;
    logic [N-1:0]   vec_q;
    logic [3:0]     wait_q;
    logic [N:0]     err_cnt_q;
    logic [N:0]     err_cnt_d;
    logic [N-1:0]   first_err_q;
    logic           busy_q;
    logic           done_q;
    logic           pass_q;
    logic           mismatch;
`ifdef SWEEP_TRUTH_TABLE_EN
    logic [(2**N)-1:0] tt_q;
`endif

    // Expected gate response is the NOR of every bit currently driven.
    always_comb begin
        mismatch  = (y_in != ~(|vec_q));
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + (N+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            wait_q      <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
`ifdef SWEEP_TRUTH_TABLE_EN
            tt_q        <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= DRIVE;
                        vec_q       <= '0;
                        wait_q      <= '0;
                        err_cnt_q   <= '0;
                        first_err_q <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
`ifdef SWEEP_TRUTH_TABLE_EN
                        tt_q        <= '0;
`endif
                    end
                end
                DRIVE: begin
                    wait_q  <= '0;
                    state_q <= (SETTLE == 0) ? SAMPLE : WAIT;
                end
                WAIT: begin
                    if (wait_q == 4'(SETTLE - 1)) begin
                        wait_q  <= '0;
                        state_q <= SAMPLE;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    err_cnt_q <= err_cnt_d;
                    if (mismatch && (err_cnt_q == '0)) begin
                        first_err_q <= vec_q;
                    end
`ifdef SWEEP_TRUTH_TABLE_EN
                    tt_q[vec_q] <= y_in;
`endif
                    // Last vector stays on vec so the final stimulus remains visible.
                    if (vec_q == '1) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end else begin
                        vec_q   <= vec_q + N'(1);
                        state_q <= DRIVE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vec       = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;
`ifdef SWEEP_TRUTH_TABLE_EN
    assign tt        = tt_q;
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: three instances with SETTLE = 1, 0 and 3,
// each fed by a behavioural gate whose function (NOR, stuck-0, OR) is selectable.
module tb_gate_sweep_checker;

    logic       clk;
    logic       rst;
    logic       start [3];
    logic [1:0] vec_w [3];
    logic       y_w   [3];
    logic       busy_w[3];
    logic       done_w[3];
    logic       pass_w[3];
    logic [2:0] err_w [3];
    logic [1:0] ferr_w[3];
`ifdef SWEEP_TRUTH_TABLE_EN
    logic [3:0] tt_w  [3];
`endif
    int         mode;
    int         passed;
    int         total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic gate(input int m, input logic [1:0] v);
        case (m)
            1:       return 1'b0;
            2:       return |v;
            default: return ~(|v);
        endcase
    endfunction

    assign y_w[0] = gate(mode, vec_w[0]);
    assign y_w[1] = gate(mode, vec_w[1]);
    assign y_w[2] = gate(mode, vec_w[2]);

    gate_sweep_checker #(.N(2), .SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start[0]), .vec(vec_w[0]), .y_in(y_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]),
        .first_err(ferr_w[0])
`ifdef SWEEP_TRUTH_TABLE_EN
        , .tt(tt_w[0])
`endif
    );

    gate_sweep_checker #(.N(2), .SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start[1]), .vec(vec_w[1]), .y_in(y_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]),
        .first_err(ferr_w[1])
`ifdef SWEEP_TRUTH_TABLE_EN
        , .tt(tt_w[1])
`endif
    );

    gate_sweep_checker #(.N(2), .SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start[2]), .vec(vec_w[2]), .y_in(y_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_cnt(err_w[2]),
        .first_err(ferr_w[2])
`ifdef SWEEP_TRUTH_TABLE_EN
        , .tt(tt_w[2])
`endif
    );

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    // Pulse start on instance d, then count cycles until done (-1 on timeout).
    // vec_bad counts vec changes away from a vector-window boundary or to a wrong value.
    task automatic run(input int d, input int inject_at, output int cycles,
                       output int vec_bad, output logic busy_first);
        int         win;
        logic [1:0] prev;
        win     = settle_of(d) + 2;
        cycles  = -1;
        vec_bad = 0;
        @(posedge clk); #1;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d]   = 1'b0;
        busy_first = busy_w[d];
        prev       = vec_w[d];
        if (prev !== 2'd0) vec_bad++;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            start[d] = (i == inject_at);
            if (vec_w[d] !== prev) begin
                if ((i % win) != 0 || int'(vec_w[d]) != i / win) vec_bad++;
                prev = vec_w[d];
            end
            if (done_w[d] === 1'b1) begin
                cycles = i;
                break;
            end
        end
        start[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({vec_w[d], busy_w[d], done_w[d], pass_w[d], err_w[d], ferr_w[d]} !== 10'd0) begin
                $display("FAIL reset_outputs[%0d]: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d ferr=%0d, want all 0",
                         d, vec_w[d], busy_w[d], done_w[d], pass_w[d], err_w[d], ferr_w[d]);
            end else passed++;
        end
    endtask

    task automatic check_result(input string nm, input int cyc, input int cyc_exp,
                                input int d, input logic p_exp, input logic [2:0] e_exp,
                                input logic [1:0] f_exp, input logic [3:0] tt_exp);
        total++;
        if (cyc != cyc_exp) $display("FAIL %s_cycles: got %0d want %0d", nm, cyc, cyc_exp);
        else passed++;
        total++;
        if (pass_w[d] !== p_exp) $display("FAIL %s_pass: got %0b want %0b", nm, pass_w[d], p_exp);
        else passed++;
        total++;
        if (err_w[d] !== e_exp) $display("FAIL %s_err_cnt: got %0d want %0d", nm, err_w[d], e_exp);
        else passed++;
        total++;
        if (ferr_w[d] !== f_exp) $display("FAIL %s_first_err: got %0d want %0d", nm, ferr_w[d], f_exp);
        else passed++;
        total++;
        if (busy_w[d] !== 1'b0 || vec_w[d] !== 2'd3)
            $display("FAIL %s_final: got busy=%0b vec=%0d want busy=0 vec=3", nm, busy_w[d], vec_w[d]);
        else passed++;
`ifdef SWEEP_TRUTH_TABLE_EN
        total++;
        if (tt_w[d] !== tt_exp) $display("FAIL %s_tt: got %b want %b", nm, tt_w[d], tt_exp);
        else passed++;
`endif
    endtask

    task automatic test_nor();
        int cyc, bad;
        logic b1;
        mode = 0;
        run(0, 0, cyc, bad, b1);
        total++;
        if (b1 !== 1'b1) $display("FAIL nor_busy_after_start: got %0b want 1", b1);
        else passed++;
        total++;
        if (bad != 0) $display("FAIL nor_vec_window: got %0d bad changes want 0", bad);
        else passed++;
        check_result("nor", cyc, 12, 0, 1'b1, 3'd0, 2'd0, 4'b0001);
    endtask

    task automatic test_stuck0();
        int cyc, bad;
        logic b1;
        mode = 1;
        run(0, 0, cyc, bad, b1);
        check_result("stuck0", cyc, 12, 0, 1'b0, 3'd1, 2'd0, 4'b0000);
    endtask

    task automatic test_or();
        int cyc, bad;
        logic b1;
        mode = 2;
        run(0, 0, cyc, bad, b1);
        check_result("or", cyc, 12, 0, 1'b0, 3'd4, 2'd0, 4'b1110);
    endtask

    task automatic test_rst_mid();
        int cyc, bad;
        logic b1;
        int seen;
        mode = 1;
        seen = 0;
        @(posedge clk); #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (vec_w[0] === 2'd2) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (seen != 1 || err_w[0] !== 3'd1)
            $display("FAIL rst_mid_reach_vec2: got seen=%0d err=%0d want seen=1 err=1", seen, err_w[0]);
        else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({vec_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], ferr_w[0]} !== 10'd0)
            $display("FAIL rst_mid_outputs: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d, want all 0",
                     vec_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0]);
        else passed++;
        mode = 0;
        run(0, 0, cyc, bad, b1);
        check_result("rst_rerun", cyc, 12, 0, 1'b1, 3'd0, 2'd0, 4'b0001);
    endtask

    task automatic test_back_to_back();
        int cyc, bad;
        logic b1;
        mode = 0;
        run(0, 5, cyc, bad, b1);
        check_result("start_busy", cyc, 12, 0, 1'b1, 3'd0, 2'd0, 4'b0001);
        mode = 2;
        run(0, 0, cyc, bad, b1);
        total++;
        if (b1 !== 1'b1) $display("FAIL restart_busy: got %0b want 1", b1);
        else passed++;
        check_result("restart_done", cyc, 12, 0, 1'b0, 3'd4, 2'd0, 4'b1110);
    endtask

    task automatic test_settle();
        int cyc, bad;
        logic b1;
        mode = 0;
        run(1, 0, cyc, bad, b1);
        total++;
        if (bad != 0) $display("FAIL settle0_vec_window: got %0d bad changes want 0", bad);
        else passed++;
        check_result("settle0", cyc, 8, 1, 1'b1, 3'd0, 2'd0, 4'b0001);
        run(2, 0, cyc, bad, b1);
        total++;
        if (bad != 0) $display("FAIL settle3_vec_window: got %0d bad changes want 0", bad);
        else passed++;
        check_result("settle3", cyc, 20, 2, 1'b1, 3'd0, 2'd0, 4'b0001);
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        mode     = 0;
        rst      = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        start[2] = 1'b0;
        test_reset();
        test_nor();
        test_stuck0();
        test_or();
        test_rst_mid();
        test_back_to_back();
        test_settle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SHALL have parameter N, default 2: width of the gate input vector driven (sweep length 2^N).
REQ-002 SHALL have parameter SETTLE, default 1, range 0..15: idle cycles between driving a vector and sampling the gate output.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a sweep.
REQ-006 SHALL have port vec  output  N  stimulus to the downstream NOR gate inputs (vec[N-1] = a, vec[0] = b for N=2).
REQ-007 SHALL have port y_in  input  1  gate output returned from the NOR gate under check.
REQ-008 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port done  output  1  high from sweep completion until the next start or rst.
REQ-010 SHALL have port pass  output  1  valid while done: 1 when err_cnt is 0.
REQ-011 SHALL have port err_cnt  output  N+1  number of mismatching vectors in the last sweep.
REQ-012 SHALL have port first_err  output  N  vec value of the first mismatch; 0 if there was none.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, WAIT, SAMPLE, DONE.
REQ-014 IDLE: on start, SHALL clear vec, err_cnt and first_err, then go to DRIVE.
REQ-015 DRIVE: vec SHALL hold the current vector for one cycle, then go to WAIT; if SETTLE=0, go directly to SAMPLE.
REQ-016 WAIT: SHALL count SETTLE cycles with vec held stable, then go to SAMPLE.
REQ-017 SAMPLE: SHALL compare y_in against the expected value, which is the NOR of all bits of vec.
REQ-018 On a mismatch, SHALL increment err_cnt; if err_cnt was 0, SHALL also capture vec into first_err.
REQ-019 SAMPLE, vector not last: SHALL increment vec by 1 and go to DRIVE.
REQ-020 SAMPLE, last vector (vec = 2^N-1): SHALL go to DONE and SHALL NOT wrap vec; vec holds 2^N-1.
REQ-021 Each vector SHALL occupy exactly SETTLE+2 cycles; a full sweep SHALL take 2^N*(SETTLE+2) cycles from the cycle after start to the done rising edge.
REQ-022 busy SHALL be high in DRIVE, WAIT and SAMPLE; done SHALL be high only in DONE.
REQ-023 start while busy SHALL be ignored.
REQ-024 start in DONE SHALL restart the sweep exactly as from IDLE.
REQ-025 err_cnt SHALL saturate at 2^N, its maximum possible value, and SHALL never wrap.
REQ-026 y_in SHALL be sampled only in SAMPLE; its value in all other states is don't-care.

Reset
REQ-027 rst SHALL force IDLE, vec=0, busy=0, done=0, pass=0, err_cnt=0, first_err=0, and clear the WAIT counter.
REQ-028 rst asserted mid-sweep SHALL abort the sweep; no partial result is retained.
REQ-029 rst SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro SWEEP_TRUTH_TABLE_EN defined: SHALL add port tt  output  2^N  where tt[k] is y_in as sampled for vector k.
REQ-031 With SWEEP_TRUTH_TABLE_EN defined: tt SHALL be cleared on start and on rst.
REQ-032 Macro SWEEP_TRUTH_TABLE_EN undefined: the tt port and its storage SHALL be absent; all other behaviour is unchanged.

Verification
REQ-033 N=2, SETTLE=1, correct NOR gate, pulse start -> done after 12 cycles, pass=1, err_cnt=0, first_err=0, tt=4'b0001 (macro on).
REQ-034 y_in stuck at 0 -> err_cnt=1, first_err=2'b00, pass=0.
REQ-035 y_in driven by an OR gate -> err_cnt=4, first_err=0, pass=0.
REQ-036 rst asserted during vector 2 -> next cycle: IDLE, all outputs 0; a following start completes a full clean sweep.
REQ-037 start repeated while busy -> ignored; done occurs at cycle 12 as usual. start in DONE -> done drops and a new sweep begins.
REQ-038 SETTLE=0 -> done after 8 cycles; SETTLE=3 -> done after 20 cycles; vec stable throughout each vector's window.
